vga_mode_ctrl: RTL and testbench
================================

// Module: vga_mode_ctrl
// PURPOSE
//  Video-mode sequencer in front of the VGA timing generator. Holds a 4-entry mode table.
//  Accepts mode-change requests over a valid/ready handshake and waits for the end of the
//  current frame. Then writes the new porch/sync/display values with a 1-cycle we_o pulse.
//  Blanks video until the new timing has run SETTLE_FRAMES complete frames.
// PARAMETERS
//  H_W            11    width of horizontal timing fields/counter (matches VGA_MAX_H_WIDTH)
//  V_W            10    width of vertical timing fields/counter (matches VGA_MAX_V_WIDTH)
//  DEFAULT_MODE   0     mode loaded automatically after reset (must be 0..2)
//  SETTLE_FRAMES  2     full frames to blank after a load (>=1)
//  TIMEOUT_CYCLES 2**22 max cycles in WAIT_FRAME before a forced load
// PORTS
//  clk_i        in   1    pixel clock
//  arstn_i      in   1    async active-low reset
//  req_valid_i  in   1    mode-change request valid
//  req_mode_i   in   2    requested mode index
//  req_ready_o  out  1    high only in IDLE; request accepted when valid&&ready
//  done_o       out  1    1-cycle pulse: accepted request completed
//  err_o        out  1    1-cycle pulse: accepted request named unsupported mode 3
//  blank_o      out  1    force RGB black (timing unstable)
//  cur_mode_o   out  2    mode currently written to timing generator
//  hcount_i     in   H_W  horizontal counter from timing generator
//  vcount_i     in   V_W  vertical counter from timing generator
//  hd_o,hf_o,hr_o,hb_o  out  H_W  display/front porch/sync/back porch (registered)
//  vd_o,vf_o,vr_o,vb_o  out  V_W  same, vertical (registered)
//  we_o         out  1    1-cycle write strobe to timing generator
// BEHAVIOUR
//  - Mode table (hd,hf,hr,hb / vd,vf,vr,vb):
//      0 = 640,16,96,48 / 480,10,2,33
//      1 = 800,40,128,88 / 600,1,4,23
//      2 = 1024,24,136,160 / 768,3,6,29
//      3 = unsupported
//  - Internal htot/vtot registers hold the sums for cur_mode_o. They are updated together
//    with we_o. Sums are computed at full H_W/V_W width; all table sums fit (max 1344/806).
//  - frame_end = (hcount_i == htot-1) && (vcount_i == vtot-1), using registered htot/vtot.
//  - Reset values: state INIT, hd_o..vb_o=0, htot=vtot=0, we_o=0, req_ready_o=0,
//    done_o=0, err_o=0, blank_o=1, cur_mode_o=DEFAULT_MODE.
//  - FSM:
//    INIT       : 1 cycle after reset release -> LOAD with DEFAULT_MODE (no frame wait).
//    IDLE       : req_ready_o=1, blank_o=0. On accept:
//                   mode 3           -> err_o pulse next cycle, stay IDLE
//                   mode==cur_mode_o -> done_o pulse next cycle, stay IDLE, no write
//                   else             -> latch mode, blank_o=1 next cycle, -> WAIT_FRAME
//    WAIT_FRAME : count cycles. On frame_end -> LOAD. If count reaches TIMEOUT_CYCLES-1
//                 -> LOAD (forced).
//    LOAD       : we_o=1 for exactly this cycle. Outputs present the new table entry in
//                 the same cycle. cur_mode_o/htot/vtot update at this cycle's end.
//                 -> SETTLE, frame counter cleared.
//    SETTLE     : count frame_end using new htot/vtot. On SETTLE_FRAMES-th frame_end:
//                   after INIT -> IDLE with no done_o
//                   otherwise  -> DONE
//    DONE       : done_o=1 for this cycle, blank_o=0 -> IDLE.
//  - Latency: accepted request to we_o = (cycles to next frame_end)+1. blank_o deasserts
//    the cycle after the final settle frame_end.
//  - req_ready_o low outside IDLE. Requests in other states are not accepted and must be
//    held by the requester. A request coincident with DONE is accepted only next cycle.
//  - err_o and done_o never assert together. we_o never asserts outside LOAD.
//  - Reset mid-operation: immediate return to reset values. In-flight request dropped, no
//    done_o/err_o. Default mode reloads via INIT.
// TESTING
//  - Reset release, counters free-running: we_o single pulse 1 cycle after INIT,
//    hd_o=640 vd_o=480. blank_o falls after 2 frames of 800x525. No done_o.
//  - IDLE, req mode 1: ready drops; we_o exactly 1 cycle after hcount=799 & vcount=524;
//    hd_o=800 hr_o=128 vb_o=23; done_o after 2 frames of 1056x628.
//  - req mode 3: err_o pulse 1 cycle after accept; no we_o; cur_mode_o unchanged;
//    blank_o stays 0.
//  - req mode == cur_mode_o: done_o 1 cycle after accept; no we_o, no blank.
//  - Counters held at 0 after request for mode 2 (TIMEOUT_CYCLES=64): forced we_o after
//    64 cycles in WAIT_FRAME with hd_o=1024.
//  - arstn_i low during SETTLE: all outputs return to reset values asynchronously;
//    afterwards mode 0 reloads, no done_o for the dropped request.

Source files
------------

// File: rtl/vga_mode_ctrl.sv
// Video-mode sequencer: swaps the timing generator between table modes on a frame
// boundary, then holds video blanked until the new timing has settled.
module vga_mode_ctrl #(
    parameter int H_W            = 11,
    parameter int V_W            = 10,
    parameter int DEFAULT_MODE   = 0,
    parameter int SETTLE_FRAMES  = 2,
    parameter int TIMEOUT_CYCLES = 2**22
) (
    input  logic           clk_i,
    input  logic           arstn_i,
    input  logic           req_valid_i,
    input  logic [1:0]     req_mode_i,
    output logic           req_ready_o,
    output logic           done_o,
    output logic           err_o,
    output logic           blank_o,
    output logic [1:0]     cur_mode_o,
    input  logic [H_W-1:0] hcount_i,
    input  logic [V_W-1:0] vcount_i,
    output logic [H_W-1:0] hd_o,
    output logic [H_W-1:0] hf_o,
    output logic [H_W-1:0] hr_o,
    output logic [H_W-1:0] hb_o,
    output logic [V_W-1:0] vd_o,
    output logic [V_W-1:0] vf_o,
    output logic [V_W-1:0] vr_o,
    output logic [V_W-1:0] vb_o,
    output logic           we_o
);

    localparam int TO_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int SF_W = $clog2(SETTLE_FRAMES + 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_WAIT_FRAME,
        S_LOAD,
        S_SETTLE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [H_W-1:0] hd;
        logic [H_W-1:0] hf;
        logic [H_W-1:0] hr;
        logic [H_W-1:0] hb;
        logic [V_W-1:0] vd;
        logic [V_W-1:0] vf;
        logic [V_W-1:0] vr;
        logic [V_W-1:0] vb;
    } timing_t;

    // Mode 3 is rejected before it can reach LOAD, so it shares the mode 0 row.
    function automatic timing_t mode_entry(input logic [1:0] mode);
        timing_t t;
        case (mode)
            2'd1: begin
                t.hd = H_W'(800);  t.hf = H_W'(40); t.hr = H_W'(128); t.hb = H_W'(88);
                t.vd = V_W'(600);  t.vf = V_W'(1);  t.vr = V_W'(4);   t.vb = V_W'(23);
            end
            2'd2: begin
                t.hd = H_W'(1024); t.hf = H_W'(24); t.hr = H_W'(136); t.hb = H_W'(160);
                t.vd = V_W'(768);  t.vf = V_W'(3);  t.vr = V_W'(6);   t.vb = V_W'(29);
            end
            default: begin
                t.hd = H_W'(640);  t.hf = H_W'(16); t.hr = H_W'(96);  t.hb = H_W'(48);
                t.vd = V_W'(480);  t.vf = V_W'(10); t.vr = V_W'(2);   t.vb = V_W'(33);
            end
        endcase
        return t;
    endfunction

    state_t          r_state;
    state_t          w_next_state;
    logic [1:0]      r_tgt_mode;
    logic [1:0]      r_cur_mode;
    logic            r_from_init;
    logic [TO_W-1:0] r_wait_cnt;
    logic [SF_W-1:0] r_frm_cnt;
    logic [H_W-1:0]  r_hd, r_hf, r_hr, r_hb, r_htot;
    logic [V_W-1:0]  r_vd, r_vf, r_vr, r_vb, r_vtot;
    logic            r_we;
    logic            r_done;
    logic            r_err;
    logic            r_blank;

    logic            w_accept;
    logic            w_req_bad;
    logic            w_req_same;
    logic            w_frame_end;
    logic            w_timeout;
    logic            w_settled;
    timing_t         w_entry;

    assign w_accept    = (r_state == S_IDLE) && req_valid_i;
    assign w_req_bad   = (req_mode_i == 2'd3);
    assign w_req_same  = !w_req_bad && (req_mode_i == r_cur_mode);
    assign w_frame_end = (hcount_i == r_htot - H_W'(1)) && (vcount_i == r_vtot - V_W'(1));
    assign w_timeout   = (r_wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));
    assign w_settled   = w_frame_end && (r_frm_cnt == SF_W'(SETTLE_FRAMES - 1));
    assign w_entry     = mode_entry(r_tgt_mode);

    // NOTE: next state gets its default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_INIT:       w_next_state = S_LOAD;
            S_IDLE:       if (w_accept && !w_req_bad && !w_req_same) w_next_state = S_WAIT_FRAME;
            S_WAIT_FRAME: if (w_frame_end || w_timeout) w_next_state = S_LOAD;
            S_LOAD:       w_next_state = S_SETTLE;
            S_SETTLE:     if (w_settled) w_next_state = r_from_init ? S_IDLE : S_DONE;
            S_DONE:       w_next_state = S_IDLE;
            default:      w_next_state = S_INIT;
        endcase
    end

    // NOTE: all state uses non-blocking assignments so every register samples the
    // values from before this edge, independent of statement order.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            r_state     <= S_INIT;
            r_tgt_mode  <= 2'(DEFAULT_MODE);
            r_cur_mode  <= 2'(DEFAULT_MODE);
            r_from_init <= 1'b1;
            r_wait_cnt  <= '0;
            r_frm_cnt   <= '0;
            r_hd        <= '0;
            r_hf        <= '0;
            r_hr        <= '0;
            r_hb        <= '0;
            r_vd        <= '0;
            r_vf        <= '0;
            r_vr        <= '0;
            r_vb        <= '0;
            r_htot      <= '0;
            r_vtot      <= '0;
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_blank     <= 1'b1;
        end else begin
            r_state <= w_next_state;
            r_we    <= (w_next_state == S_LOAD);
            r_blank <= !((w_next_state == S_IDLE) || (w_next_state == S_DONE));
            r_done  <= (w_next_state == S_DONE) || (w_accept && w_req_same);
            r_err   <= w_accept && w_req_bad;

            if ((r_state == S_IDLE) && (w_next_state == S_WAIT_FRAME)) begin
                r_tgt_mode  <= req_mode_i;
                r_from_init <= 1'b0;
            end

            r_wait_cnt <= (r_state == S_WAIT_FRAME) ? r_wait_cnt + 1'b1 : '0;

            // Timing fields change on entry to LOAD so they are valid alongside we_o.
            if (w_next_state == S_LOAD) begin
                r_hd <= w_entry.hd;
                r_hf <= w_entry.hf;
                r_hr <= w_entry.hr;
                r_hb <= w_entry.hb;
                r_vd <= w_entry.vd;
                r_vf <= w_entry.vf;
                r_vr <= w_entry.vr;
                r_vb <= w_entry.vb;
            end

            if (r_state == S_LOAD) begin
                r_cur_mode <= r_tgt_mode;
                r_htot     <= r_hd + r_hf + r_hr + r_hb;
                r_vtot     <= r_vd + r_vf + r_vr + r_vb;
                r_frm_cnt  <= '0;
            end else if ((r_state == S_SETTLE) && w_frame_end) begin
                r_frm_cnt  <= r_frm_cnt + 1'b1;
            end
        end
    end

    assign req_ready_o = (r_state == S_IDLE);
    assign done_o      = r_done;
    assign err_o       = r_err;
    assign blank_o     = r_blank;
    assign cur_mode_o  = r_cur_mode;
    assign we_o        = r_we;
    assign hd_o        = r_hd;
    assign hf_o        = r_hf;
    assign hr_o        = r_hr;
    assign hb_o        = r_hb;
    assign vd_o        = r_vd;
    assign vf_o        = r_vf;
    assign vr_o        = r_vr;
    assign vb_o        = r_vb;

endmodule

// File: tb/tb_vga_mode_ctrl.sv
// Directed bench for vga_mode_ctrl: write/done/err pulses go through an expectation
// queue; level outputs are checked inline at each step.
module tb_vga_mode_ctrl;

    localparam int H_W = 11;
    localparam int V_W = 10;
    localparam int TO  = 64;

    logic           clk_i = 1'b0;
    logic           arstn_i = 1'b0;
    logic           req_valid_i = 1'b0;
    logic [1:0]     req_mode_i = 2'd0;
    logic           req_ready_o, done_o, err_o, blank_o, we_o;
    logic [1:0]     cur_mode_o;
    logic [H_W-1:0] hcount_i = '0;
    logic [V_W-1:0] vcount_i = '0;
    logic [H_W-1:0] hd_o, hf_o, hr_o, hb_o;
    logic [V_W-1:0] vd_o, vf_o, vr_o, vb_o;

    vga_mode_ctrl #(
        .H_W(H_W), .V_W(V_W), .DEFAULT_MODE(0), .SETTLE_FRAMES(2), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk_i(clk_i), .arstn_i(arstn_i),
        .req_valid_i(req_valid_i), .req_mode_i(req_mode_i), .req_ready_o(req_ready_o),
        .done_o(done_o), .err_o(err_o), .blank_o(blank_o), .cur_mode_o(cur_mode_o),
        .hcount_i(hcount_i), .vcount_i(vcount_i),
        .hd_o(hd_o), .hf_o(hf_o), .hr_o(hr_o), .hb_o(hb_o),
        .vd_o(vd_o), .vf_o(vf_o), .vr_o(vr_o), .vb_o(vb_o),
        .we_o(we_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int hd, hf, hr, hb, vd, vf, vr, vb;
    } tim_t;

    typedef struct {
        string      tag;
        logic [2:0] kind;   // {we, done, err}
        int         cyc;
        int         mode;
    } exp_t;

    localparam logic [2:0] K_WE   = 3'b100;
    localparam logic [2:0] K_DONE = 3'b010;
    localparam logic [2:0] K_ERR  = 3'b001;

    tim_t tbl [3];
    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic expect_ev(input string tag, input logic [2:0] kind, input int at, input int mode);
        exp_t e;
        e.tag  = tag;
        e.kind = kind;
        e.cyc  = at;
        e.mode = mode;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic sample();
        @(negedge clk_i);
    endtask

    task automatic set_cnt(input int h, input int v);
        step();
        hcount_i = H_W'(h);
        vcount_i = V_W'(v);
    endtask

    // Counters show (h,v) for one cycle; on return the DUT's reaction is visible.
    task automatic frame_pulse(input int h, input int v);
        set_cnt(h, v);
        set_cnt(0, 0);
    endtask

    // Pulse scoreboard: every we/done/err pulse must match the oldest expectation.
    always @(negedge clk_i) begin
        exp_t e;
        if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            e = exp_q.pop_front();
            chk({e.tag, "_missing_at_cycle"}, cyc, e.cyc);
        end
        if (we_o || done_o || err_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", {29'd0, we_o, done_o, err_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk({e.tag, "_kind"}, {29'd0, we_o, done_o, err_o}, {29'd0, e.kind});
                chk({e.tag, "_cycle"}, cyc, e.cyc);
                if (e.kind == K_WE) begin
                    chk({e.tag, "_hd"}, hd_o, tbl[e.mode].hd);
                    chk({e.tag, "_hf"}, hf_o, tbl[e.mode].hf);
                    chk({e.tag, "_hr"}, hr_o, tbl[e.mode].hr);
                    chk({e.tag, "_hb"}, hb_o, tbl[e.mode].hb);
                    chk({e.tag, "_vd"}, vd_o, tbl[e.mode].vd);
                    chk({e.tag, "_vf"}, vf_o, tbl[e.mode].vf);
                    chk({e.tag, "_vr"}, vr_o, tbl[e.mode].vr);
                    chk({e.tag, "_vb"}, vb_o, tbl[e.mode].vb);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{640, 16, 96, 48, 480, 10, 2, 33};   // totals 800 x 525
        tbl[1] = '{800, 40, 128, 88, 600, 1, 4, 23};   // totals 1056 x 628
        tbl[2] = '{1024, 24, 136, 160, 768, 3, 6, 29}; // totals 1344 x 806

        // Reset values while arstn_i is held low.
        repeat (3) step();
        sample();
        chk("rst_we", we_o, 0);
        chk("rst_blank", blank_o, 1);
        chk("rst_ready", req_ready_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", err_o, 0);
        chk("rst_hd", hd_o, 0);
        chk("rst_vb", vb_o, 0);
        chk("rst_cur", cur_mode_o, 0);

        // Release: INIT for one cycle, then a write of mode 0 with no frame wait.
        step();
        arstn_i = 1'b1;
        expect_ev("boot_we", K_WE, cyc + 1, 0);
        sample();
        chk("init_ready", req_ready_o, 0);
        chk("init_blank", blank_o, 1);
        repeat (3) step();
        sample();
        chk("settle0_blank", blank_o, 1);
        chk("settle0_ready", req_ready_o, 0);

        // Half-matching counter values must not count as frame ends.
        set_cnt(799, 100);
        set_cnt(10, 524);
        frame_pulse(799, 524);
        sample();
        chk("settle0_after1_blank", blank_o, 1);
        frame_pulse(799, 524);
        sample();
        chk("boot_blank_off", blank_o, 0);
        chk("boot_ready", req_ready_o, 1);
        chk("boot_cur", cur_mode_o, 0);

        // Mode 1 request: waits for the 800x525 frame end, then settles on 1056x628.
        step();
        req_valid_i = 1'b1;
        req_mode_i  = 2'd1;
        sample();
        chk("m1_ready_before", req_ready_o, 1);
        step();
        req_valid_i = 1'b0;
        sample();
        chk("m1_ready_wait", req_ready_o, 0);
        chk("m1_blank_wait", blank_o, 1);
        repeat (5) step();
        expect_ev("m1_we", K_WE, cyc + 2, 1);
        frame_pulse(799, 524);
        step();
        frame_pulse(799, 524);
        sample();
        chk("m1_stale_frame_blank", blank_o, 1);
        frame_pulse(1055, 627);
        sample();
        chk("m1_settle1_blank", blank_o, 1);
        expect_ev("m1_done", K_DONE, cyc + 2, 0);
        frame_pulse(1055, 627);
        sample();
        chk("m1_done_blank", blank_o, 0);
        chk("m1_done_ready", req_ready_o, 0);
        step();
        sample();
        chk("m1_cur", cur_mode_o, 1);
        chk("m1_idle_ready", req_ready_o, 1);

        // Unsupported mode 3: error pulse, nothing else changes.
        step();
        req_valid_i = 1'b1;
        req_mode_i  = 2'd3;
        expect_ev("m3_err", K_ERR, cyc + 1, 0);
        step();
        req_valid_i = 1'b0;
        sample();
        chk("m3_blank", blank_o, 0);
        chk("m3_cur", cur_mode_o, 1);
        chk("m3_ready", req_ready_o, 1);

        // Request for the current mode: done next cycle, no write, no blanking.
        step();
        req_valid_i = 1'b1;
        req_mode_i  = 2'd1;
        expect_ev("same_done", K_DONE, cyc + 1, 0);
        step();
        req_valid_i = 1'b0;
        sample();
        chk("same_blank", blank_o, 0);
        chk("same_ready", req_ready_o, 1);

        // Mode 2 with counters stuck at 0: forced load after TO cycles of waiting.
        step();
        req_valid_i = 1'b1;
        req_mode_i  = 2'd2;
        expect_ev("to_we", K_WE, cyc + 1 + TO, 2);
        step();
        req_valid_i = 1'b0;
        repeat (30) step();
        sample();
        chk("to_wait_blank", blank_o, 1);
        chk("to_wait_hd_old", hd_o, 800);
        repeat (40) step();
        sample();
        chk("to_cur", cur_mode_o, 2);
        frame_pulse(1343, 805);
        sample();
        chk("to_settle_blank", blank_o, 1);

        // Asynchronous reset in SETTLE: immediate reset values, request dropped.
        step();
        arstn_i = 1'b0;
        #1;
        chk("arst_we", we_o, 0);
        chk("arst_blank", blank_o, 1);
        chk("arst_hd", hd_o, 0);
        chk("arst_vd", vd_o, 0);
        chk("arst_cur", cur_mode_o, 0);
        chk("arst_ready", req_ready_o, 0);
        repeat (2) step();
        arstn_i = 1'b1;
        expect_ev("reboot_we", K_WE, cyc + 1, 0);
        repeat (3) step();
        frame_pulse(799, 524);
        frame_pulse(799, 524);
        sample();
        chk("reboot_blank", blank_o, 0);
        chk("reboot_cur", cur_mode_o, 0);
        chk("reboot_ready", req_ready_o, 1);

        repeat (3) step();
        sample();
        chk("exp_q_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
